// File: rtl/fibl_pkg.sv
// Shared primitives for the Fibonacci engine: datapath width, vector type, FSM states.
package fibl_pkg;

  localparam int INT_N = 16;

  typedef logic [INT_N-1:0] int_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/fibl_step.sv
// One Fibonacci recurrence step: (x, y) -> (y, x + y), wrapping mod 2^N.
module fibl_step
  import fibl_pkg::*;
#(
  parameter int N = INT_N
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N-1:0] x_nxt,
  output logic [N-1:0] y_nxt
);

  assign x_nxt = y;
  assign y_nxt = x + y;

endmodule

// File: rtl/fibl.sv
// Iterative Fibonacci engine: samples index on read, steps once per clock,
// then pulses write for one cycle with F(a) mod 2^N on b.
module fibl
  import fibl_pkg::*;
#(
  parameter int N = INT_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         read,
  input  logic [N-1:0] a,
  output logic [N-1:0] b,
  output logic         write
);

  state_e       state_q, state_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic [N-1:0] x_q, x_d;
  logic [N-1:0] y_q, y_d;
  logic [N-1:0] b_q, b_d;
  logic         write_q, write_d;
  logic [N-1:0] x_nxt, y_nxt;

  fibl_step #(.N(N)) u_step (
    .x     (x_q),
    .y     (y_q),
    .x_nxt (x_nxt),
    .y_nxt (y_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      b_q     <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      b_q     <= b_d;
      write_q <= write_d;
    end
  end

  // A read always (re)starts, so it overrides the terminating step.
  always_comb begin
    state_d = state_q;
    if (read)
      state_d = RUN;
    else if (state_q == RUN && cnt_q == '0)
      state_d = IDLE;
  end

  always_comb begin
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    b_d     = b_q;
    write_d = 1'b0;
    if (read) begin
      cnt_d = a;
      x_d   = '0;
      y_d   = N'(1);
    end else if (state_q == RUN) begin
      if (cnt_q != '0) begin
        x_d   = x_nxt;
        y_d   = y_nxt;
        cnt_d = cnt_q - N'(1);
      end else begin
        b_d     = x_q;
        write_d = 1'b1;
      end
    end
  end

  assign b     = b_q;
  assign write = write_q;

endmodule

// File: tb/tb_fibl.sv
// Randomized self-checking bench for fibl against an exact-arithmetic Fibonacci model.
module tb_fibl;

  logic        clk = 1'b0;
  logic        rst;
  logic        read;
  logic [15:0] a;
  logic [15:0] b;
  logic        write;

  int total = 0;
  int bad   = 0;

  fibl dut (
    .clk   (clk),
    .rst   (rst),
    .read  (read),
    .a     (a),
    .b     (b),
    .write (write)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Exact Fibonacci (fits 64 bits for k<=90), reduced to the 16-bit result width.
  function automatic logic [31:0] fib_ref(input int k);
    longint unsigned f0, f1, t;
    f0 = 0;
    f1 = 1;
    for (int i = 0; i < k; i++) begin
      t  = f0 + f1;
      f0 = f1;
      f1 = t;
    end
    return 32'(f0 % 65536);
  endfunction

  // One-cycle read pulse; returns at the negedge after the sampling edge.
  task automatic do_read(input int idx);
    @(negedge clk);
    read = 1'b1;
    a    = 16'(idx);
    @(negedge clk);
    read = 1'b0;
  endtask

  // Expect write exactly idx+1 edges after the sampling edge, silent before.
  task automatic wait_write(input int idx, input string tag);
    int early = 0;
    for (int c = 1; c <= idx + 1; c++) begin
      @(posedge clk);
      #1;
      if (c <= idx) begin
        if (write) early++;
      end else begin
        chk({tag, "_write"}, 32'(write), 32'd1);
        chk({tag, "_b"}, 32'(b), fib_ref(idx));
      end
    end
    chk({tag, "_early"}, 32'(early), 32'd0);
  endtask

  task automatic run_req(input int idx, input string tag);
    do_read(idx);
    wait_write(idx, tag);
    @(posedge clk);
    #1;
    chk({tag, "_pulse1"}, 32'(write), 32'd0);
  endtask

  task automatic quiet_cycles(input int n, input logic [15:0] exp_b, input string tag);
    int wr = 0;
    int bb = 0;
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      if (write) wr++;
      if (b !== exp_b) bb++;
    end
    chk({tag, "_nowrite"}, 32'(wr), 32'd0);
    chk({tag, "_hold"}, 32'(bb), 32'd0);
  endtask

  initial begin
    int idx, gap;
    rst  = 1'b1;
    read = 1'b0;
    a    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_b", 32'(b), 32'd0);
    chk("rst_write", 32'(write), 32'd0);
    quiet_cycles(10, 16'd0, "idle");

    run_req(21, "a21");
    quiet_cycles(100, 16'd10946, "a21");

    run_req(0, "a0");
    run_req(1, "a1");
    run_req(2, "a2");
    run_req(24, "a24");
    run_req(25, "a25");

    // Restart mid-run: second read sampled 6 edges after the first.
    do_read(21);
    quiet_cycles(5, 16'd9489, "rs_pre");
    run_req(5, "rs5");

    // Restart coinciding with the terminating step of a=3.
    do_read(3);
    quiet_cycles(3, 16'd5, "coinc_pre");
    run_req(2, "coinc2");

    // Read held for several edges: only the last sampled index counts.
    @(negedge clk);
    read = 1'b1; a = 16'd9;
    @(negedge clk);
    a = 16'd4;
    @(negedge clk);
    a = 16'd6;
    @(negedge clk);
    read = 1'b0;
    wait_write(6, "held6");

    // Reset mid-run aborts silently and clears b.
    do_read(21);
    quiet_cycles(8, 16'd8, "rm_pre");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rm_b", 32'(b), 32'd0);
    quiet_cycles(30, 16'd0, "rm_post");
    run_req(10, "after_rst");

    // Back-to-back: next read the cycle after write.
    do_read(3);
    wait_write(3, "bb3");
    do_read(7);
    wait_write(7, "bb7");

    // Random indices, some with a restart partway through.
    for (int n = 0; n < 25; n++) begin
      idx = $urandom_range(0, 60);
      if ($urandom_range(0, 3) == 0 && idx > 2) begin
        do_read(idx);
        gap = $urandom_range(0, idx - 1);
        for (int c = 0; c < gap; c++) begin
          @(posedge clk);
          #1;
          chk("rnd_abort", 32'(write), 32'd0);
        end
        idx = $urandom_range(0, 60);
      end
      run_req(idx, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fibl.md
Name: fibl

Overview:
- Iterative Fibonacci engine.
- Accepts an unsigned index `a` on a one-cycle `read` strobe.
- Steps a two-register Fibonacci recurrence once per clock.
- Presents F(a) on `b` with a one-cycle `write` strobe.
- Leaf compute block driven by a generated top or a testbench; no downstream back-pressure.

Parameters:
- N, 16, data width of `a`, `b` and all internal datapath registers; the codebase's intN / intT width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- read  input  1  start strobe; samples `a` on the rising edge where read=1
- a  input  N  unsigned Fibonacci index
- b  output  N  result F(a) mod 2^N; held until the next result
- write  output  1  result-valid strobe, one cycle wide

Behaviour:
- Definition: F(0)=0, F(1)=1, F(k)=F(k-1)+F(k-2). All additions wrap mod 2^N; no overflow flag.
- State: `cnt`(N), `x`(N), `y`(N), and `busy`(1); two states, IDLE and RUN.
- Reset (synchronous, rst=1 at a rising edge): busy=0, b=0, write=0, cnt=x=y=0. Reset has priority over read. Reset mid-RUN aborts the computation with no write pulse.
- IDLE, read=1: cnt<=a, x<=0, y<=1, busy<=1, write<=0.
- RUN, read=0:
  - cnt!=0: x<=y, y<=x+y, cnt<=cnt-1.
  - cnt==0: b<=x, write<=1, busy<=0.
- write is high for exactly one cycle, in the cycle after the terminating RUN step; otherwise write<=0 every cycle.
- Latency: write/b valid a+1 rising edges after the edge that sampled read. For a=21: 22 cycles, b=10946.
- read=1 while busy: restart. Reload cnt/x/y from the new `a`; the pending result is discarded and produces no write.
- read=1 in the same cycle the terminating step would fire: restart wins, no write.
- read held high for several cycles: each edge reloads, so computation starts from the last sampled `a`.
- b changes only on a write cycle or on reset; it holds its last value between results.
- No X propagation: every register is assigned on reset.

Decomposition:
- Shared package / include (primitives): the N width define (intN) and the `intT` vector type.
- Optional sub-module `fibl_step`: combinational, (x,y) -> (y, x+y) wrapping adder. The FSM and registers stay in `fibl`.

Test Plan:
- rst=1 for 2 cycles, then idle with read=0 for 10 cycles -> b=0, write=0 throughout.
- read=1 for one cycle with a=21 -> write pulses once, 22 cycles later, b=10946; b holds 10946 for the next 100 cycles.
- Boundary indices, each as a separate read:
  - a=0 -> b=0 after 1 cycle.
  - a=1 -> b=1 after 2 cycles.
  - a=2 -> b=1.
  - a=24 -> b=46368.
  - a=25 -> b=9489 (75025 mod 65536, wrap).
- a=21 started, then read=1 with a=5 after 6 cycles -> no write for 21; one write 6 cycles later with b=5.
- a=21 started, rst=1 for one cycle mid-run -> write never asserts, b=0. A following read with a=10 -> b=55, write 11 cycles later.
- Back-to-back: read a=3, wait for write (b=2), read a=7 on the next cycle -> b=13. Exactly one write per request.
